// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the memory port arbiter:
//   - arb_state_t and the ARB_IDLE / ARB_REQ / ARB_RESP state encodings
//   - requester IDs ARB_R0 (instruction fetch) and ARB_R1 (load/store unit)
//   - rr_pick(): the round-robin winner selection used in IDLE
package mem_port_arbiter_pkg;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ARB_IDLE = 2'd0;
   localparam arb_state_t ARB_REQ  = 2'd1;
   localparam arb_state_t ARB_RESP = 2'd2;

   localparam logic ARB_R0 = 1'b0;
   localparam logic ARB_R1 = 1'b1;

   // A lone requester always wins. On a tie, the requester that was not
   // served last wins, which alternates the grant under continuous load.
   function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
      logic winner;
      if (v0 && v1) begin
         winner = ~last;
      end else if (v1) begin
         winner = ARB_R1;
      end else begin
         winner = ARB_R0;
      end
      return winner;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two requester handshakes and the memory port handshake.
//
//   Handshake semantics (all channels): a transfer happens in a cycle where
//   valid and ready are both high at the rising clock edge. Once valid is
//   raised the requester holds it and its payload stable until ready is seen.
//   Response strobes (rN_resp_valid, mem_resp_valid) are single-cycle pulses
//   with no back-pressure.
//
//   Signals:
//     r0_req_valid / r0_req_ready / r0_resp_valid   requester 0 (fetch)
//     r1_req_valid / r1_req_ready / r1_resp_valid   requester 1 (load/store)
//     mem_req_valid / mem_req_ready / mem_resp_valid  shared memory port
//     mem_sel   steering select for the external payload muxes (0 = r0, 1 = r1)
//
//   Modports:
//     slave   the arbiter itself
//     master  the surrounding requesters and memory
interface mem_port_arbiter_if;

   logic r0_req_valid;
   logic r0_req_ready;
   logic r0_resp_valid;
   logic r1_req_valid;
   logic r1_req_ready;
   logic r1_resp_valid;
   logic mem_req_valid;
   logic mem_req_ready;
   logic mem_resp_valid;
   logic mem_sel;

   modport slave (
      input  r0_req_valid,
      output r0_req_ready,
      output r0_resp_valid,
      input  r1_req_valid,
      output r1_req_ready,
      output r1_resp_valid,
      output mem_req_valid,
      input  mem_req_ready,
      input  mem_resp_valid,
      output mem_sel
   );

   modport master (
      output r0_req_valid,
      input  r0_req_ready,
      input  r0_resp_valid,
      output r1_req_valid,
      input  r1_req_ready,
      input  r1_resp_valid,
      input  mem_req_valid,
      output mem_req_ready,
      output mem_resp_valid,
      input  mem_sel
   );

endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// sat_counter
//   Event counter that stops at all-ones instead of wrapping.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset, clears the count
//     inc    count one event this cycle
//     count  current value, CNT_WIDTH bits
module sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between requester 0 (instruction fetch) and
//   requester 1 (load/store unit) with a round-robin arbiter and a single
//   outstanding transaction. mem_sel drives the external payload muxes;
//   read data is broadcast outside this block.
//
//   Optional feature: define MEM_ARB_PERF_EN to build the saturating perf
//   counters. Without it the counter outputs are tied to 0 and no counter
//   flops exist; arbitration is the same either way.
//
//   Ports:
//     clk           system clock, rising edge
//     rst_n         asynchronous active-low reset
//     bus           mem_port_arbiter_if.slave, requester and memory handshakes
//     gnt_cnt0      grants (req_ready handshakes) to requester 0
//     gnt_cnt1      grants (req_ready handshakes) to requester 1
//     conflict_cnt  IDLE cycles with both requesters valid
//     dbg_state     current FSM state for observation
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mem_port_arbiter_if.slave    bus,
   output logic [CNT_WIDTH-1:0] gnt_cnt0,
   output logic [CNT_WIDTH-1:0] gnt_cnt1,
   output logic [CNT_WIDTH-1:0] conflict_cnt,
   output arb_state_t           dbg_state
);

   arb_state_t state;
   arb_state_t state_next;
   logic       owner;
   logic       owner_next;
   logic       last_grant;
   logic       last_grant_next;

   // last_grant resets to r1 so that r0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         owner      <= ARB_R0;
         last_grant <= ARB_R1;
      end else begin
         state      <= state_next;
         owner      <= owner_next;
         last_grant <= last_grant_next;
      end
   end

   // owner only changes on the IDLE->REQ transition, so it is frozen for the
   // whole transaction and keeps its last value while idle.
   always_comb begin
      state_next      = state;
      owner_next      = owner;
      last_grant_next = last_grant;
      case (state)
         ARB_IDLE: begin
            if (bus.r0_req_valid || bus.r1_req_valid) begin
               owner_next = rr_pick(bus.r0_req_valid, bus.r1_req_valid, last_grant);
               state_next = ARB_REQ;
            end
         end
         ARB_REQ: begin
            if (bus.mem_req_ready) begin
               state_next = ARB_RESP;
            end
         end
         ARB_RESP: begin
            if (bus.mem_resp_valid) begin
               last_grant_next = owner;
               state_next      = ARB_IDLE;
            end
         end
         default: begin
            state_next = ARB_IDLE;
         end
      endcase
   end

   // Ready and response are combinational pass-throughs of the memory side,
   // gated to the owner; mem_resp_valid outside RESP never reaches a requester.
   always_comb begin
      bus.mem_req_valid = 1'b0;
      bus.r0_req_ready  = 1'b0;
      bus.r1_req_ready  = 1'b0;
      bus.r0_resp_valid = 1'b0;
      bus.r1_resp_valid = 1'b0;
      bus.mem_sel       = owner;
      case (state)
         ARB_REQ: begin
            bus.mem_req_valid = 1'b1;
            bus.r0_req_ready  = bus.mem_req_ready && (owner == ARB_R0);
            bus.r1_req_ready  = bus.mem_req_ready && (owner == ARB_R1);
         end
         ARB_RESP: begin
            bus.r0_resp_valid = bus.mem_resp_valid && (owner == ARB_R0);
            bus.r1_resp_valid = bus.mem_resp_valid && (owner == ARB_R1);
         end
         default: begin
         end
      endcase
   end

   assign dbg_state = state;

`ifdef MEM_ARB_PERF_EN
   logic conflict;
   assign conflict = (state == ARB_IDLE) && bus.r0_req_valid && bus.r1_req_valid;

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_gnt_cnt0 (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (bus.r0_req_ready),
      .count (gnt_cnt0)
   );

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_gnt_cnt1 (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (bus.r1_req_ready),
      .count (gnt_cnt1)
   );

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_conflict_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (conflict),
      .count (conflict_cnt)
   );
`else
   assign gnt_cnt0     = '0;
   assign gnt_cnt1     = '0;
   assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter: directed scenarios followed by
//   randomized requester/memory traffic, all compared against a
//   transaction-level reference model every cycle on the falling edge.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus ();
   logic [CW-1:0] gnt_cnt0;
   logic [CW-1:0] gnt_cnt1;
   logic [CW-1:0] conflict_cnt;
   arb_state_t    dbg_state;

   mem_port_arbiter #(.CNT_WIDTH(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .gnt_cnt0     (gnt_cnt0),
      .gnt_cnt1     (gnt_cnt1),
      .conflict_cnt (conflict_cnt),
      .dbg_state    (dbg_state)
   );

   // ---------------- checking ----------------
   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A transaction is either absent, waiting for memory acceptance, or
   // waiting for its response. last_srv is who finished most recently.
   bit m_busy;
   bit m_acc;
   bit m_own;
   bit m_last_srv;
   int m_g0;
   int m_g1;
   int m_cf;
   logic [0:0] exp_q[$];   // scoreboard: predicted grant order

   function automatic int sat(input int x);
      return (x > CMAX) ? CMAX : x;
   endfunction

   task automatic model_reset();
      m_busy     = 1'b0;
      m_acc      = 1'b0;
      m_own      = 1'b0;
      m_last_srv = 1'b1;
      m_g0 = 0;
      m_g1 = 0;
      m_cf = 0;
      exp_q.delete();
   endtask

   task automatic model_update();
      bit w;
      if (!m_busy) begin
         if (bus.r0_req_valid && bus.r1_req_valid) m_cf = sat(m_cf + 1);
         if (bus.r0_req_valid || bus.r1_req_valid) begin
            if (bus.r0_req_valid && bus.r1_req_valid) w = !m_last_srv;
            else w = bus.r1_req_valid;
            m_own  = w;
            m_busy = 1'b1;
            m_acc  = 1'b0;
            exp_q.push_back(w);
         end
      end else if (!m_acc) begin
         if (bus.mem_req_ready) begin
            m_acc = 1'b1;
            if (m_own) m_g1 = sat(m_g1 + 1);
            else m_g0 = sat(m_g0 + 1);
         end
      end else if (bus.mem_resp_valid) begin
         m_busy     = 1'b0;
         m_last_srv = m_own;
      end
   endtask

   // ---------------- driver state ----------------
   bit v0, v1, mrdy, mresp;
   int cyc = 0;
   int rdy_cyc = -1;
   int resp_cyc = -1;
   int obs_rdy = 0;
   int obs_resp = 0;
   int gnt_log[$];

   task automatic check_outputs();
      bit e_mv, e_rdy0, e_rdy1, e_rsp0, e_rsp1;
      arb_state_t e_st;
      logic [0:0] e_w;
      e_mv   = m_busy && !m_acc;
      e_rdy0 = e_mv && bus.mem_req_ready && !m_own;
      e_rdy1 = e_mv && bus.mem_req_ready && m_own;
      e_rsp0 = m_busy && m_acc && bus.mem_resp_valid && !m_own;
      e_rsp1 = m_busy && m_acc && bus.mem_resp_valid && m_own;
      e_st   = !m_busy ? ARB_IDLE : (!m_acc ? ARB_REQ : ARB_RESP);
      chk("mem_req_valid", bus.mem_req_valid, e_mv);
      chk("mem_sel", bus.mem_sel, m_own);
      chk("r0_req_ready", bus.r0_req_ready, e_rdy0);
      chk("r1_req_ready", bus.r1_req_ready, e_rdy1);
      chk("r0_resp_valid", bus.r0_resp_valid, e_rsp0);
      chk("r1_resp_valid", bus.r1_resp_valid, e_rsp1);
      chk("state", dbg_state, e_st);
      chk("one_ready", bus.r0_req_ready && bus.r1_req_ready, 1'b0);
      chk("one_resp", bus.r0_resp_valid && bus.r1_resp_valid, 1'b0);
`ifdef MEM_ARB_PERF_EN
      chk("gnt_cnt0", gnt_cnt0, m_g0);
      chk("gnt_cnt1", gnt_cnt1, m_g1);
      chk("conflict_cnt", conflict_cnt, m_cf);
`else
      chk("gnt_cnt0", gnt_cnt0, 0);
      chk("gnt_cnt1", gnt_cnt1, 0);
      chk("conflict_cnt", conflict_cnt, 0);
`endif
      if (bus.r0_req_ready || bus.r1_req_ready) begin
         obs_rdy++;
         rdy_cyc = cyc;
         gnt_log.push_back(int'(bus.r1_req_ready));
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_grant", 1, 0);
         end else begin
            e_w = exp_q.pop_front();
            chk("sb_grant_owner", bus.r1_req_ready, e_w);
         end
      end
      if (bus.r0_resp_valid || bus.r1_resp_valid) begin
         obs_resp++;
         resp_cyc = cyc;
      end
      // A requester releases valid once its request has been accepted.
      if (e_rdy0) v0 = 1'b0;
      if (e_rdy1) v1 = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; drives inputs, checks on the falling
   // edge, then advances the model on the next rising edge.
   task automatic tick();
      bus.r0_req_valid   = v0;
      bus.r1_req_valid   = v1;
      bus.mem_req_ready  = mrdy;
      bus.mem_resp_valid = mresp;
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   // Async reset asserted mid-cycle with a memory response present, which
   // must not produce a strobe.
   task automatic apply_reset();
      v0 = 1'b0;
      v1 = 1'b0;
      mrdy = 1'b0;
      mresp = 1'b1;
      bus.r0_req_valid   = 1'b0;
      bus.r1_req_valid   = 1'b0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mresp = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int start;
      int rdy_before;
      int resp_before;
      bus.r0_req_valid   = 1'b0;
      bus.r1_req_valid   = 1'b0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      apply_reset();

      // 1: r0 alone, zero-wait memory: ready one cycle and response two
      //    cycles after the cycle valid is first presented.
      mrdy = 1'b1;
      mresp = 1'b1;
      v0 = 1'b1;
      start = cyc;
      for (int i = 0; i < 4; i++) tick();
      chk("t1_ready_latency", rdy_cyc - start, 1);
      chk("t1_resp_latency", resp_cyc - start, 2);

      // 2: both valid continuously, grants alternate starting with r0.
      apply_reset();
      gnt_log.delete();
      mrdy = 1'b1;
      mresp = 1'b1;
      for (int i = 0; i < 12; i++) begin
         v0 = 1'b1;
         v1 = 1'b1;
         tick();
      end
      chk("t2_grant_count", gnt_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < gnt_log.size()) chk("t2_grant_order", gnt_log[i], i % 2);
      end

      // 3: memory stalls 5 cycles in REQ, then completes.
      apply_reset();
      v0 = 1'b0;
      v1 = 1'b1;
      mrdy = 1'b0;
      mresp = 1'b0;
      rdy_before = obs_rdy;
      resp_before = obs_resp;
      for (int i = 0; i < 6; i++) tick();
      chk("t3_stall_state", dbg_state, ARB_REQ);
      chk("t3_no_ready", obs_rdy - rdy_before, 0);
      mrdy = 1'b1;
      mresp = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("t3_ready_done", obs_rdy - rdy_before, 1);
      chk("t3_resp_done", obs_resp - resp_before, 1);

      // 4: r1 wins once so last_grant=r1 would not help; put r1 in RESP,
      //    reset, then a tie must go to r0.
      mrdy = 1'b1;
      mresp = 1'b0;
      v1 = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("t4_in_resp", dbg_state, ARB_RESP);
      resp_before = obs_resp;
      apply_reset();
      chk("t4_no_resp", obs_resp - resp_before, 0);
      gnt_log.delete();
      v0 = 1'b1;
      v1 = 1'b1;
      mrdy = 1'b1;
      mresp = 1'b1;
      for (int i = 0; i < 2; i++) tick();
      chk("t4_tie_size", gnt_log.size(), 1);
      if (gnt_log.size() > 0) chk("t4_tie_r0", gnt_log[0], 0);
      for (int i = 0; i < 8; i++) tick();

      // 5: spurious memory response while idle.
      v0 = 1'b0;
      v1 = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      resp_before = obs_resp;
      mresp = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("t5_no_strobe", obs_resp - resp_before, 0);
      chk("t5_state_idle", dbg_state, ARB_IDLE);

      // 6: five r1 grants saturate a 2-bit counter.
      apply_reset();
      mrdy = 1'b1;
      mresp = 1'b1;
      for (int i = 0; i < 15; i++) begin
         v1 = 1'b1;
         tick();
      end
`ifdef MEM_ARB_PERF_EN
      chk("t6_gnt1_sat", gnt_cnt1, 3);
`else
      chk("t6_gnt1_off", gnt_cnt1, 0);
`endif
      chk("t6_gnt0_zero", gnt_cnt0, 0);

      // Randomized traffic, including stalls and spurious responses.
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         if (!v0 && ($urandom_range(0, 3) == 0)) v0 = 1'b1;
         if (!v1 && ($urandom_range(0, 3) == 0)) v1 = 1'b1;
         mrdy  = ($urandom_range(0, 1) == 1);
         mresp = ($urandom_range(0, 2) != 0);
         tick();
         if ($urandom_range(0, 199) == 0) apply_reset();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Safety net in case a timing control ever stalls.
   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule
